request_unit: RTL and testbench

//  Fetch/memory-sequencing stage directly upstream of the control unit. It owns the PC and the

---
 rtl/request_unit.sv | 74 +++++++
 tb/tb_request_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/request_unit.sv
// Fetch/memory sequencing stage: owns PC and instruction register, turns the control
// unit's level requests into single held memory transactions, and emits retire strobes.
module request_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  input  logic              dhit,
  input  logic              cu_dREN,
  input  logic              cu_dWEN,
  input  logic              cu_halt,
  input  logic [WORD_W-1:0] next_pc,
  output logic [WORD_W-1:0] imemaddr,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              wb_en,
  output logic              halt
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] EXEC   = 2'd1;
  localparam logic [1:0] MEM    = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0] state, state_nxt;
  logic       mem_op;

  assign mem_op = cu_dREN | cu_dWEN;

  // Outputs are pure decodes of state, so reset immediately drops any in-flight request.
  assign iREN     = (state == FETCH);
  assign dREN     = (state == MEM) & cu_dREN;
  assign dWEN     = (state == MEM) & cu_dWEN;
  assign halt     = (state == HALTED);
  assign wb_en    = ((state == EXEC) & ~cu_halt & ~mem_op) | ((state == MEM) & dhit);
  assign imemaddr = pc;
  assign pc_plus4 = pc + WORD_W'(4);

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (ihit) state_nxt = EXEC;
      EXEC: begin
        if (cu_halt)     state_nxt = HALTED;
        else if (mem_op) state_nxt = MEM;
        else             state_nxt = FETCH;
      end
      MEM:     if (dhit) state_nxt = FETCH;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= FETCH;
      pc          <= PC_INIT;
      instruction <= '0;
    end else begin
      state <= state_nxt;
      if ((state == FETCH) && ihit) instruction <= iload;
      // PC only advances on the edge that ends a retire cycle.
      if (wb_en) pc <= next_pc;
    end
  end

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit: retire records queued at EXEC, checked on wb_en.
module tb_request_unit;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        ihit = 1'b0, dhit = 1'b0, cu_dREN = 1'b0, cu_dWEN = 1'b0, cu_halt = 1'b0;
  logic [31:0] iload = '0, next_pc = '0;
  logic [31:0] imemaddr, instruction, pc, pc_plus4;
  logic        iREN, dREN, dWEN, wb_en, halt;

  request_unit #(.PC_INIT(32'h0), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .dhit(dhit),
    .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt), .next_pc(next_pc),
    .imemaddr(imemaddr), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .instruction(instruction), .pc(pc), .pc_plus4(pc_plus4), .wb_en(wb_en), .halt(halt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] npc;
  } sb_t;

  sb_t         sb[$];
  int          n_chk = 0, n_pass = 0;
  logic [31:0] pc_model = 32'h0;
  logic        pend = 1'b0;
  logic [31:0] pend_pc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Retire monitor: every wb_en must match the oldest queued record; PC must follow next edge.
  always @(negedge CLK) begin
    if (nRST) begin
      if (pend) begin
        chk("pc_upd", pc, pend_pc);
        pend = 1'b0;
      end
      chk("excl", {31'b0, iREN & (dREN | dWEN)}, 32'h0);
      if (wb_en) begin
        if (sb.size() == 0) chk("wb_unexp", {31'b0, wb_en}, 32'h0);
        else begin
          sb_t e;
          e = sb.pop_front();
          chk("ret_ins", instruction, e.ins);
          chk("ret_pc", pc, e.pc);
          pend    = 1'b1;
          pend_pc = e.npc;
        end
      end
    end
  end

  // Called right after a posedge with the DUT in FETCH.
  task automatic do_instr(input logic [31:0] ins, input logic [31:0] npc, input logic rd,
                          input logic wr, input logic hl, input int iwait, input int dwait);
    logic [31:0] exp_pc;
    exp_pc = pc_model;
    for (int i = 0; i < iwait; i++) begin
      ihit = 1'b0; dhit = (i == 0); iload = 32'hDEAD_BEEF;
      @(negedge CLK);
      chk("f_iren", {31'b0, iREN}, 32'h1);
      chk("f_addr", imemaddr, exp_pc);
      chk("f_p4", pc_plus4, exp_pc + 32'd4);
      chk("f_wb", {31'b0, wb_en}, 32'h0);
      step();
    end
    ihit = 1'b1; dhit = 1'b0; iload = ins;
    @(negedge CLK);
    chk("f_iren", {31'b0, iREN}, 32'h1);
    step();
    ihit = 1'b0; iload = '0;
    cu_dREN = rd; cu_dWEN = wr; cu_halt = hl; next_pc = npc;
    if (!hl && !rd && !wr) sb.push_back('{ins, exp_pc, npc});
    @(negedge CLK);
    chk("x_ins", instruction, ins);
    chk("x_iren", {31'b0, iREN}, 32'h0);
    chk("x_dreq", {30'b0, dREN, dWEN}, 32'h0);
    if (hl) begin
      chk("x_wb", {31'b0, wb_en}, 32'h0);
      step();
      cu_dREN = 1'b1;
      for (int i = 0; i < 4; i++) begin
        ihit = i[0]; dhit = ~i[0];
        @(negedge CLK);
        chk("h_halt", {31'b0, halt}, 32'h1);
        chk("h_iren", {31'b0, iREN}, 32'h0);
        chk("h_dren", {31'b0, dREN}, 32'h0);
        chk("h_wb", {31'b0, wb_en}, 32'h0);
        chk("h_pc", pc, exp_pc);
        chk("h_ins", instruction, ins);
        step();
      end
      ihit = 1'b0; dhit = 1'b0; cu_dREN = 1'b0; cu_halt = 1'b0;
      return;
    end
    if (rd || wr) begin
      sb.push_back('{ins, exp_pc, npc});
      step();
      for (int i = 0; i < dwait; i++) begin
        ihit = 1'b1; dhit = 1'b0;
        @(negedge CLK);
        chk("m_dreq", {30'b0, dREN, dWEN}, {30'b0, rd, wr});
        chk("m_iren", {31'b0, iREN}, 32'h0);
        chk("m_wb", {31'b0, wb_en}, 32'h0);
        chk("m_pc", pc, exp_pc);
        step();
      end
      ihit = 1'b0; dhit = 1'b1;
      @(negedge CLK);
      chk("m_dreq", {30'b0, dREN, dWEN}, {30'b0, rd, wr});
      chk("m_wb", {31'b0, wb_en}, 32'h1);
      step();
      dhit = 1'b0;
      // Control unit still asserts its request; the block must have dropped it.
      @(negedge CLK);
      chk("a_dreq", {30'b0, dREN, dWEN}, 32'h0);
      chk("a_iren", {31'b0, iREN}, 32'h1);
    end else begin
      step();
    end
    cu_dREN = 1'b0; cu_dWEN = 1'b0; next_pc = '0;
    pc_model = npc;
    if (rd || wr) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_iren", {31'b0, iREN}, 32'h1);
    chk("rst_dreq", {29'b0, dREN, dWEN, wb_en}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ins", instruction, 32'h0);
    chk("rst_halt", {31'b0, halt}, 32'h0);
    @(negedge CLK); nRST = 1'b1;
    step();

    do_instr(32'h2001_0005, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 3, 0);
    do_instr(32'h8C22_0000, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 1, 2);
    do_instr(32'hAC22_0004, 32'h0000_000C, 1'b0, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(0, 2));
      do_instr($urandom, pc_model + 32'd4, kind == 2'd1, kind == 2'd2, 1'b0,
               $urandom_range(0, 2), $urandom_range(0, 3));
    end
    do_instr(32'h0800_0000, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1, 0);
    do_instr(32'h0800_0004, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 2, 0);

    // Reset while a load is in flight in MEM.
    ihit = 1'b1; iload = 32'h8C23_0000;
    step();
    ihit = 1'b0; cu_dREN = 1'b1; next_pc = 32'h14;
    step();
    @(negedge CLK);
    chk("pre_dren", {31'b0, dREN}, 32'h1);
    #2 nRST = 1'b0;
    sb.delete(); pend = 1'b0;
    #1;
    chk("ar_dren", {31'b0, dREN}, 32'h0);
    chk("ar_pc", pc, 32'h0);
    chk("ar_iren", {31'b0, iREN}, 32'h1);
    chk("ar_wb", {31'b0, wb_en}, 32'h0);
    chk("ar_ins", instruction, 32'h0);
    cu_dREN = 1'b0; next_pc = '0;
    @(negedge CLK); nRST = 1'b1;
    pc_model = 32'h0;
    step();

    do_instr(32'h2002_0001, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1, 0);
    do_instr(32'hFC00_0000, 32'h0000_0044, 1'b0, 1'b0, 1'b1, 1, 0);

    chk("sb_empty", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
